// File: rtl/arb_pkg.sv
// Shared arbitration types and helpers, intended for reuse by wider N:1 arbiters.
package arb_pkg;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    localparam grant_e RESET_LAST_GRANT = GRANT_B;

    // Round-robin pick: a lone requester wins; on contention the source not granted last wins.
    function automatic grant_e rr_pick(input logic a_req, input logic b_req, input grant_e last);
        grant_e pick;
        if (a_req && b_req) begin
            pick = (last == GRANT_A) ? GRANT_B : GRANT_A;
        end else if (b_req) begin
            pick = GRANT_B;
        end else begin
            pick = GRANT_A;
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arb_2to1_if.sv
// Bundle of the two source streams and the output stream of the 2:1 arbiter.
interface rr_arb_2to1_if #(
    parameter int BIT_WIDTH = 8
);
    logic                 a_valid;
    logic [BIT_WIDTH-1:0] a_data;
    logic                 a_ready;
    logic                 b_valid;
    logic [BIT_WIDTH-1:0] b_data;
    logic                 b_ready;
    logic                 y_valid;
    logic [BIT_WIDTH-1:0] y_data;
    logic                 y_ready;
    logic                 sel;

    // master: the environment driving sources and sinking the output
    modport master (
        output a_valid, a_data, b_valid, b_data, y_ready,
        input  a_ready, b_ready, y_valid, y_data, sel
    );

    // slave: the arbiter itself
    modport slave (
        input  a_valid, a_data, b_valid, b_data, y_ready,
        output a_ready, b_ready, y_valid, y_data, sel
    );
endinterface

// File: rtl/mux_2to1.sv
// Plain combinational 2:1 data multiplexer.
module mux_2to1 #(
    parameter int BIT_WIDTH = 8
) (
    input  logic                 sel_i,
    input  logic [BIT_WIDTH-1:0] a_i,
    input  logic [BIT_WIDTH-1:0] b_i,
    output logic [BIT_WIDTH-1:0] y_o
);
    assign y_o = sel_i ? b_i : a_i;
endmodule

// File: rtl/rr_arb_2to1.sv
// Two-source round-robin arbiter feeding a single registered output stage (EMPTY/FULL FSM).
module rr_arb_2to1
    import arb_pkg::*;
#(
    parameter int BIT_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 a_valid_i,
    input  logic [BIT_WIDTH-1:0] a_data_i,
    output logic                 a_ready_o,
    input  logic                 b_valid_i,
    input  logic [BIT_WIDTH-1:0] b_data_i,
    output logic                 b_ready_o,
    output logic                 y_valid_o,
    output logic [BIT_WIDTH-1:0] y_data_o,
    input  logic                 y_ready_i,
    output logic                 sel_o
);

    state_e               state_reg, state_next;
    grant_e               last_grant_reg, last_grant_next;
    grant_e               sel_reg, sel_next;
    grant_e               grant;
    logic [BIT_WIDTH-1:0] y_data_reg, y_data_next;
    logic [BIT_WIDTH-1:0] mux_y;
    logic                 load_en;
    logic                 have_grant;

    mux_2to1 #(
        .BIT_WIDTH(BIT_WIDTH)
    ) u_mux (
        .sel_i(grant),
        .a_i  (a_data_i),
        .b_i  (b_data_i),
        .y_o  (mux_y)
    );

    always_comb begin
        load_en         = (state_reg == EMPTY) || y_ready_i;
        have_grant      = a_valid_i || b_valid_i;
        grant           = rr_pick(a_valid_i, b_valid_i, last_grant_reg);
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        sel_next        = sel_reg;
        y_data_next     = y_data_reg;

        // Readies are masked during reset so nothing is consumed in that cycle.
        a_ready_o = !rst_i && load_en && have_grant && (grant == GRANT_A);
        b_ready_o = !rst_i && load_en && have_grant && (grant == GRANT_B);

        if (load_en) begin
            if (have_grant) begin
                state_next      = FULL;
                y_data_next     = mux_y;
                sel_next        = grant;
                last_grant_next = grant;
            end else begin
                // Data and sel keep their stale values; only the valid drops.
                state_next = EMPTY;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= EMPTY;
            last_grant_reg <= RESET_LAST_GRANT;
            sel_reg        <= GRANT_A;
            y_data_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            sel_reg        <= sel_next;
            y_data_reg     <= y_data_next;
        end
    end

    assign y_valid_o = (state_reg == FULL);
    assign y_data_o  = y_data_reg;
    assign sel_o     = (sel_reg == GRANT_B);

endmodule

// File: tb/tb_rr_arb_2to1.sv
// Directed and random checks of rr_arb_2to1 with immediate assertions and a beat scoreboard.
module tb_rr_arb_2to1;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    rr_arb_2to1_if #(.BIT_WIDTH(8)) bus ();

    rr_arb_2to1 #(
        .BIT_WIDTH(8)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .a_valid_i(bus.a_valid),
        .a_data_i (bus.a_data),
        .a_ready_o(bus.a_ready),
        .b_valid_i(bus.b_valid),
        .b_data_i (bus.b_data),
        .b_ready_o(bus.b_ready),
        .y_valid_o(bus.y_valid),
        .y_data_o (bus.y_data),
        .y_ready_i(bus.y_ready),
        .sel_o    (bus.sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after a falling edge; readies are then stable until the next rising edge.
    task automatic drive(input logic r, input logic av, input logic [7:0] ad,
                         input logic bv, input logic [7:0] bd, input logic yr);
        rst         = r;
        bus.a_valid = av;
        bus.a_data  = ad;
        bus.b_valid = bv;
        bus.b_data  = bd;
        bus.y_ready = yr;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    logic [8:0] sb[$];
    logic [8:0] beat;
    logic [7:0] exp_d;
    logic       exp_a;
    logic       av, bv, yr, ld, ga, gb;
    logic [7:0] ad, bd;
    logic       m_valid, m_sel, m_last;
    logic [7:0] m_data;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        bus.a_valid = 1'b0; bus.a_data = 8'h00;
        bus.b_valid = 1'b0; bus.b_data = 8'h00;
        bus.y_ready = 1'b0;
        tick();

        // Reset held 3 cycles with both sources valid
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1);
            chk("rst_a_ready", bus.a_ready, 0);
            chk("rst_b_ready", bus.b_ready, 0);
            tick();
            chk("rst_y_valid", bus.y_valid, 0);
            chk("rst_sel", bus.sel, 0);
            chk("rst_y_data", bus.y_data, 8'h00);
        end

        // Contention: A wins first after reset, then strict alternation
        for (int i = 0; i < 6; i++) begin
            exp_a = (i % 2 == 0);
            exp_d = exp_a ? 8'hAA : 8'hBB;
            drive(1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1);
            chk("cont_a_ready", bus.a_ready, exp_a);
            chk("cont_b_ready", bus.b_ready, !exp_a);
            tick();
            chk("cont_y_valid", bus.y_valid, 1);
            chk("cont_y_data", bus.y_data, exp_d);
            chk("cont_sel", bus.sel, !exp_a);
        end

        // Single source A, back to back
        for (int i = 1; i <= 3; i++) begin
            exp_d = 8'(i * 8'h11);
            drive(1'b0, 1'b1, exp_d, 1'b0, 8'h00, 1'b1);
            chk("single_a_ready", bus.a_ready, 1);
            chk("single_b_ready", bus.b_ready, 0);
            tick();
            chk("single_y_data", bus.y_data, exp_d);
            chk("single_sel", bus.sel, 0);
            chk("single_y_valid", bus.y_valid, 1);
        end

        // Backpressure on a held 5C
        drive(1'b0, 1'b1, 8'h5C, 1'b0, 8'h00, 1'b1);
        tick();
        chk("bp_load", bus.y_data, 8'h5C);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 8'hA1, 1'b1, 8'hB1, 1'b0);
            chk("bp_a_ready", bus.a_ready, 0);
            chk("bp_b_ready", bus.b_ready, 0);
            tick();
            chk("bp_y_data", bus.y_data, 8'h5C);
            chk("bp_y_valid", bus.y_valid, 1);
            chk("bp_sel", bus.sel, 0);
        end
        // Last grant was A, so B wins when the sink frees up
        drive(1'b0, 1'b1, 8'hA1, 1'b1, 8'hB1, 1'b1);
        chk("bp_rel_a_ready", bus.a_ready, 0);
        chk("bp_rel_b_ready", bus.b_ready, 1);
        tick();
        chk("bp_rel_y_data", bus.y_data, 8'hB1);
        chk("bp_rel_sel", bus.sel, 1);

        // No grant: drain to EMPTY, data and sel hold
        drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("idle_a_ready", bus.a_ready, 0);
        chk("idle_b_ready", bus.b_ready, 0);
        tick();
        chk("idle_y_valid", bus.y_valid, 0);
        chk("idle_y_data", bus.y_data, 8'hB1);
        chk("idle_sel", bus.sel, 1);

        // EMPTY loads regardless of y_ready
        drive(1'b0, 1'b0, 8'h00, 1'b1, 8'h77, 1'b0);
        chk("empty_b_ready", bus.b_ready, 1);
        tick();
        chk("b77_y_data", bus.y_data, 8'h77);
        chk("b77_sel", bus.sel, 1);
        chk("b77_y_valid", bus.y_valid, 1);

        // Reset pulse while FULL discards the beat
        drive(1'b1, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1);
        chk("mrst_a_ready", bus.a_ready, 0);
        chk("mrst_b_ready", bus.b_ready, 0);
        tick();
        chk("mrst_y_valid", bus.y_valid, 0);
        chk("mrst_y_data", bus.y_data, 8'h00);
        drive(1'b0, 1'b1, 8'hAA, 1'b1, 8'hBB, 1'b1);
        chk("mrst_first_a", bus.a_ready, 1);
        tick();
        chk("mrst_y_data2", bus.y_data, 8'hAA);
        chk("mrst_sel2", bus.sel, 0);

        // Random regression against a reference model and ordered scoreboard
        m_valid = 1'b1; m_data = 8'hAA; m_sel = 1'b0; m_last = 1'b0;
        sb.push_back({1'b0, 8'hAA});
        for (int i = 0; i < 1000; i++) begin
            av = 1'($urandom_range(0, 1));
            bv = 1'($urandom_range(0, 1));
            yr = 1'($urandom_range(0, 1));
            ad = 8'($urandom);
            bd = 8'($urandom);
            drive(1'b0, av, ad, bv, bd, yr);
            ld = !m_valid || yr;
            ga = av && (!bv || m_last);
            gb = bv && (!av || !m_last);
            chk("rnd_a_ready", bus.a_ready, ld && ga);
            chk("rnd_b_ready", bus.b_ready, ld && gb);
            chk("rnd_one_ready", bus.a_ready && bus.b_ready, 0);
            if (bus.y_valid && yr) begin
                if (sb.size() == 0) begin
                    chk("rnd_dup_beat", bus.y_data, 9'h1FF);
                end else begin
                    beat = sb.pop_front();
                    chk("rnd_sb_beat", {bus.sel, bus.y_data}, beat);
                end
            end
            if (bus.a_ready && av) sb.push_back({1'b0, ad});
            if (bus.b_ready && bv) sb.push_back({1'b1, bd});
            if (ld) begin
                if (ga) begin
                    m_valid = 1'b1; m_data = ad; m_sel = 1'b0; m_last = 1'b0;
                end else if (gb) begin
                    m_valid = 1'b1; m_data = bd; m_sel = 1'b1; m_last = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
            tick();
            chk("rnd_y_valid", bus.y_valid, m_valid);
            if (m_valid) begin
                chk("rnd_y_data", bus.y_data, m_data);
                chk("rnd_sel", bus.sel, m_sel);
            end
        end
        chk("rnd_sb_level", sb.size(), m_valid);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
